// File: rtl/tdm_mux8.sv
// Round-robin 8:1 TDM multiplexer: collects words from 8 valid/ready lanes and emits
// one per cycle on a registered output tagged with its source lane index.
module tdm_mux8 #(
    parameter int DW   = 8,
    parameter int NCH  = 8,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH*DW-1:0]   in_data,
    input  logic [NCH-1:0]      in_valid,
    output logic [NCH-1:0]      in_ready,
    output logic [DW-1:0]       out_data,
    output logic [2:0]          out_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNTW-1:0]     xfer_cnt
);

    typedef enum logic {IDLE, FULL} state_t;

    state_t          state, state_nx;
    logic [2:0]      ptr;
    logic [2:0]      win_idx;
    logic [2:0]      cand;
    logic            found;
    logic            load_en;
    logic            load;
    logic [DW-1:0]   lane_data [NCH];

    assign out_valid = (state == FULL);
    assign load_en   = !out_valid || out_ready;
    assign load      = found && load_en;

    // Per-lane unpacking and grant decode; rst_n gating keeps in_ready low during reset.
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign lane_data[k] = in_data[k*DW +: DW];
        assign in_ready[k]  = rst_n && load && (win_idx == 3'(k));
    end

    // Rotating priority search starting at ptr; 3-bit sum wraps modulo 8.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr;
        cand    = ptr;
        for (int i = 0; i < NCH; i++) begin
            cand = ptr + 3'(i);
            if (!found && in_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = FULL;
            FULL:    if (out_ready && !found) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
            xfer_cnt <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                out_data <= lane_data[win_idx];
                out_sel  <= win_idx;
                ptr      <= win_idx + 3'd1;
            end
            if (out_valid && out_ready && (xfer_cnt != '1))
                xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule
